hazard_ctrl_pipe: RTL and testbench

Pipelined control-path companion to the main opcode decoder: accepts the decoded control bundle and register fields in ID, carries them through the ID/EX, EX/MEM and MEM/WB stage registers, and drives each stage's control lines. Also detects load-use hazards (stall plus bubble), resolves taken branches in ID (IF flush), and produces the EX-stage forwarding selects. Sits between the decoder and the datapath muxes/enables of the 5-stage CPU.

---
 rtl/hazard_ctrl_pipe_pkg.sv | 55 +++++
 rtl/hazard_ctrl_pipe_fwd_unit.sv | 22 ++
 rtl/hazard_ctrl_pipe.sv | 104 ++++++++++
 tb/tb_hazard_ctrl_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pipe_pkg.sv
// Shared types and constants for the pipelined control path: forward selects,
// ALUOp encodings and the packed per-stage control bundles.
package hazard_ctrl_pipe_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } idex_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic [4:0] dst;
  } exmem_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] dst;
  } memwb_t;

  // EX/MEM is the younger producer, so it is checked first; $0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       em_we,
                                         input logic [4:0] em_dst,
                                         input logic       mw_we,
                                         input logic [4:0] mw_dst);
    logic [1:0] sel;
    sel = FWD_RF;
    if (em_we && (em_dst != 5'd0) && (em_dst == src))
      sel = FWD_EXMEM;
    else if (mw_we && (mw_dst != 5'd0) && (mw_dst == src))
      sel = FWD_MEMWB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_pipe_fwd_unit.sv
// EX-stage forwarding compare for both ALU operands.
module hazard_ctrl_pipe_fwd_unit
  import hazard_ctrl_pipe_pkg::*;
(
  input  logic       exmem_reg_write_i,
  input  logic [4:0] exmem_dst_i,
  input  logic       memwb_reg_write_i,
  input  logic [4:0] memwb_dst_i,
  input  logic [4:0] idex_rs_i,
  input  logic [4:0] idex_rt_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  always_comb begin
    fwd_a_o = fwd_sel(idex_rs_i, exmem_reg_write_i, exmem_dst_i,
                      memwb_reg_write_i, memwb_dst_i);
    fwd_b_o = fwd_sel(idex_rt_i, exmem_reg_write_i, exmem_dst_i,
                      memwb_reg_write_i, memwb_dst_i);
  end

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Control-path stage registers (ID/EX, EX/MEM, MEM/WB) with load-use stall,
// ID-stage branch flush and EX-stage forwarding selects.
module hazard_ctrl_pipe
  import hazard_ctrl_pipe_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       RegDst_i,
  input  logic       ALUSrc_i,
  input  logic       RegWrite_i,
  input  logic       MemWrite_i,
  input  logic       MemRead_i,
  input  logic       MemtoReg_i,
  input  logic       Branch_i,
  input  logic [1:0] ALUOp_i,
  input  logic [4:0] Rs_i,
  input  logic [4:0] Rt_i,
  input  logic [4:0] Rd_i,
  input  logic       BranchEq_i,
  output logic       PCWrite_o,
  output logic       IF_IDWrite_o,
  output logic       IF_Flush_o,
  output logic       EX_RegDst_o,
  output logic       EX_ALUSrc_o,
  output logic [1:0] EX_ALUOp_o,
  output logic [1:0] ForwardA_o,
  output logic [1:0] ForwardB_o,
  output logic       MEM_MemWrite_o,
  output logic       MEM_MemRead_o,
  output logic       WB_RegWrite_o,
  output logic       WB_MemtoReg_o,
  output logic [4:0] WB_RegAddr_o
);

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;
  logic   stall;

  always_comb begin
    stall = idex_q.mem_read && ((idex_q.rt == Rs_i) || (idex_q.rt == Rt_i));

    // A stall leaves the zero default in place, which is the bubble.
    idex_d = '0;
    if (!stall) begin
      idex_d.reg_dst    = RegDst_i;
      idex_d.alu_op     = ALUOp_i;
      idex_d.alu_src    = ALUSrc_i;
      idex_d.reg_write  = RegWrite_i;
      idex_d.mem_write  = MemWrite_i;
      idex_d.mem_read   = MemRead_i;
      idex_d.mem_to_reg = MemtoReg_i;
      idex_d.rs         = Rs_i;
      idex_d.rt         = Rt_i;
      idex_d.rd         = Rd_i;
    end

    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.mem_read   = idex_q.mem_read;
    exmem_d.mem_to_reg = idex_q.mem_to_reg;
    exmem_d.dst        = idex_q.reg_dst ? idex_q.rd : idex_q.rt;

    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.dst        = exmem_q.dst;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  hazard_ctrl_pipe_fwd_unit u_fwd (
    .exmem_reg_write_i (exmem_q.reg_write),
    .exmem_dst_i       (exmem_q.dst),
    .memwb_reg_write_i (memwb_q.reg_write),
    .memwb_dst_i       (memwb_q.dst),
    .idex_rs_i         (idex_q.rs),
    .idex_rt_i         (idex_q.rt),
    .fwd_a_o           (ForwardA_o),
    .fwd_b_o           (ForwardB_o)
  );

  assign PCWrite_o      = !stall;
  assign IF_IDWrite_o   = !stall;
  assign IF_Flush_o     = Branch_i && BranchEq_i && !stall;
  assign EX_RegDst_o    = idex_q.reg_dst;
  assign EX_ALUSrc_o    = idex_q.alu_src;
  assign EX_ALUOp_o     = idex_q.alu_op;
  assign MEM_MemWrite_o = exmem_q.mem_write;
  assign MEM_MemRead_o  = exmem_q.mem_read;
  assign WB_RegWrite_o  = memwb_q.reg_write;
  assign WB_MemtoReg_o  = memwb_q.mem_to_reg;
  assign WB_RegAddr_o   = memwb_q.dst;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Directed bench for hazard_ctrl_pipe: stage timing, forwarding, load-use
// stall, branch flush and asynchronous reset.
module tb_hazard_ctrl_pipe;
  import hazard_ctrl_pipe_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       RegDst_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i, Branch_i;
  logic [1:0] ALUOp_i;
  logic [4:0] Rs_i, Rt_i, Rd_i;
  logic       BranchEq_i;
  logic       PCWrite_o, IF_IDWrite_o, IF_Flush_o;
  logic       EX_RegDst_o, EX_ALUSrc_o;
  logic [1:0] EX_ALUOp_o, ForwardA_o, ForwardB_o;
  logic       MEM_MemWrite_o, MEM_MemRead_o;
  logic       WB_RegWrite_o, WB_MemtoReg_o;
  logic [4:0] WB_RegAddr_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i),
    .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i), .MemtoReg_i(MemtoReg_i),
    .Branch_i(Branch_i), .ALUOp_i(ALUOp_i),
    .Rs_i(Rs_i), .Rt_i(Rt_i), .Rd_i(Rd_i), .BranchEq_i(BranchEq_i),
    .PCWrite_o(PCWrite_o), .IF_IDWrite_o(IF_IDWrite_o), .IF_Flush_o(IF_Flush_o),
    .EX_RegDst_o(EX_RegDst_o), .EX_ALUSrc_o(EX_ALUSrc_o), .EX_ALUOp_o(EX_ALUOp_o),
    .ForwardA_o(ForwardA_o), .ForwardB_o(ForwardB_o),
    .MEM_MemWrite_o(MEM_MemWrite_o), .MEM_MemRead_o(MEM_MemRead_o),
    .WB_RegWrite_o(WB_RegWrite_o), .WB_MemtoReg_o(WB_MemtoReg_o),
    .WB_RegAddr_o(WB_RegAddr_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic rdst, input logic [1:0] aop, input logic asrc,
                       input logic rw, input logic mw, input logic mr, input logic m2r,
                       input logic br, input logic eq,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    RegDst_i = rdst; ALUOp_i = aop; ALUSrc_i = asrc; RegWrite_i = rw;
    MemWrite_i = mw; MemRead_i = mr; MemtoReg_i = m2r; Branch_i = br;
    BranchEq_i = eq; Rs_i = rs; Rt_i = rt; Rd_i = rd;
    #1;
  endtask

  task automatic nop();
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic r_type(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    drive(1, ALUOP_RTYPE, 0, 1, 0, 0, 0, 0, 0, rs, rt, rd);
  endtask

  task automatic lw(input logic [4:0] rt, input logic [4:0] rs);
    drive(0, ALUOP_ADD, 1, 1, 0, 1, 1, 0, 0, rs, rt, 5'd0);
  endtask

  task automatic beq(input logic [4:0] rs, input logic [4:0] rt, input logic eq);
    drive(0, ALUOP_SUB, 0, 0, 0, 0, 0, 1, eq, rs, rt, 5'd0);
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    rst_i = 1'b0;
    drive($urandom_range(0, 1), 2'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0, 0,
          5'($urandom), 5'($urandom), 5'($urandom));
    tick();
    tick();
    outs = {EX_RegDst_o, EX_ALUSrc_o, EX_ALUOp_o, MEM_MemWrite_o, MEM_MemRead_o,
            WB_RegWrite_o, WB_MemtoReg_o, WB_RegAddr_o, 1'b0};
    checks++;
    if (outs !== 14'd0) begin
      errors++; $display("FAIL reset_stage_outs: got %h expected 0", outs);
    end
    checks++;
    if ({PCWrite_o, IF_IDWrite_o, ForwardA_o, ForwardB_o} !== 6'b110000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 110000",
                         {PCWrite_o, IF_IDWrite_o, ForwardA_o, ForwardB_o});
    end
    nop();
    rst_i = 1'b1;
    tick();
    r_type(5'd3, 5'd1, 5'd2);
    tick();
    checks++;
    if ({EX_RegDst_o, EX_ALUSrc_o, EX_ALUOp_o} !== {1'b1, 1'b0, ALUOP_RTYPE}) begin
      errors++; $display("FAIL add_ex_stage: got %b expected 1010",
                         {EX_RegDst_o, EX_ALUSrc_o, EX_ALUOp_o});
    end
    nop();
    tick();
    tick();
    checks++;
    if ({WB_RegWrite_o, WB_MemtoReg_o, WB_RegAddr_o} !== {1'b1, 1'b0, 5'd3}) begin
      errors++; $display("FAIL add_wb_stage: got %b expected 1000011",
                         {WB_RegWrite_o, WB_MemtoReg_o, WB_RegAddr_o});
    end
  endtask

  task automatic test_forwarding();
    r_type(5'd3, 5'd1, 5'd2);
    tick();
    r_type(5'd4, 5'd3, 5'd3);
    tick();
    checks++;
    if ({ForwardA_o, ForwardB_o} !== {FWD_EXMEM, FWD_EXMEM}) begin
      errors++; $display("FAIL fwd_exmem: got %b expected 1010", {ForwardA_o, ForwardB_o});
    end
    r_type(5'd3, 5'd1, 5'd2);
    tick();
    nop();
    tick();
    r_type(5'd4, 5'd3, 5'd3);
    tick();
    checks++;
    if ({ForwardA_o, ForwardB_o} !== {FWD_MEMWB, FWD_MEMWB}) begin
      errors++; $display("FAIL fwd_memwb: got %b expected 0101", {ForwardA_o, ForwardB_o});
    end
    r_type(5'd0, 5'd1, 5'd2);
    tick();
    r_type(5'd4, 5'd0, 5'd0);
    tick();
    checks++;
    if ({ForwardA_o, ForwardB_o} !== {FWD_RF, FWD_RF}) begin
      errors++; $display("FAIL fwd_zero_reg: got %b expected 0000", {ForwardA_o, ForwardB_o});
    end
    nop();
    tick();
    checks++;
    if ({WB_RegWrite_o, WB_RegAddr_o} !== {1'b1, 5'd0}) begin
      errors++; $display("FAIL zero_reg_wb: got %b expected 100000", {WB_RegWrite_o, WB_RegAddr_o});
    end
  endtask

  task automatic test_double_hit();
    r_type(5'd5, 5'd1, 5'd2);
    tick();
    r_type(5'd5, 5'd1, 5'd2);
    tick();
    r_type(5'd6, 5'd5, 5'd5);
    tick();
    checks++;
    if ({ForwardA_o, ForwardB_o} !== {FWD_EXMEM, FWD_EXMEM}) begin
      errors++; $display("FAIL fwd_double_hit: got %b expected 1010", {ForwardA_o, ForwardB_o});
    end
    nop();
    tick();
    tick();
    tick();
  endtask

  task automatic test_load_use();
    lw(5'd2, 5'd1);
    tick();
    r_type(5'd4, 5'd2, 5'd2);
    checks++;
    if ({PCWrite_o, IF_IDWrite_o} !== 2'b00) begin
      errors++; $display("FAIL load_use_stall: got %b expected 00", {PCWrite_o, IF_IDWrite_o});
    end
    tick();
    checks++;
    if ({EX_RegDst_o, EX_ALUSrc_o, EX_ALUOp_o, MEM_MemRead_o} !== 5'b00001) begin
      errors++; $display("FAIL load_use_bubble: got %b expected 00001",
                         {EX_RegDst_o, EX_ALUSrc_o, EX_ALUOp_o, MEM_MemRead_o});
    end
    checks++;
    if ({PCWrite_o, IF_IDWrite_o} !== 2'b11) begin
      errors++; $display("FAIL load_use_release: got %b expected 11", {PCWrite_o, IF_IDWrite_o});
    end
    tick();
    checks++;
    if ({ForwardA_o, ForwardB_o, WB_MemtoReg_o} !== {FWD_MEMWB, FWD_MEMWB, 1'b1}) begin
      errors++; $display("FAIL load_use_fwd: got %b expected 01011",
                         {ForwardA_o, ForwardB_o, WB_MemtoReg_o});
    end
    nop();
    tick();
    tick();
    tick();
  endtask

  task automatic test_branch();
    beq(5'd1, 5'd2, 1'b1);
    checks++;
    if (IF_Flush_o !== 1'b1) begin
      errors++; $display("FAIL branch_taken: got %b expected 1", IF_Flush_o);
    end
    beq(5'd1, 5'd2, 1'b0);
    checks++;
    if (IF_Flush_o !== 1'b0) begin
      errors++; $display("FAIL branch_not_taken: got %b expected 0", IF_Flush_o);
    end
    lw(5'd2, 5'd1);
    tick();
    beq(5'd2, 5'd3, 1'b1);
    checks++;
    if ({IF_Flush_o, PCWrite_o} !== 2'b00) begin
      errors++; $display("FAIL branch_stalled: got %b expected 00", {IF_Flush_o, PCWrite_o});
    end
    tick();
    checks++;
    if ({IF_Flush_o, PCWrite_o} !== 2'b11) begin
      errors++; $display("FAIL branch_after_stall: got %b expected 11", {IF_Flush_o, PCWrite_o});
    end
    nop();
    tick();
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    lw(5'd7, 5'd1);
    tick();
    r_type(5'd8, 5'd7, 5'd1);
    checks++;
    if (PCWrite_o !== 1'b0) begin
      errors++; $display("FAIL async_pre_stall: got %b expected 0", PCWrite_o);
    end
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if ({PCWrite_o, IF_IDWrite_o} !== 2'b11) begin
      errors++; $display("FAIL async_stall_clear: got %b expected 11", {PCWrite_o, IF_IDWrite_o});
    end
    checks++;
    if ({EX_RegDst_o, EX_ALUSrc_o, EX_ALUOp_o, MEM_MemWrite_o, MEM_MemRead_o,
         WB_RegWrite_o, WB_MemtoReg_o, WB_RegAddr_o} !== 13'd0) begin
      errors++; $display("FAIL async_outs_clear: got %b expected 0",
                         {EX_RegDst_o, EX_ALUSrc_o, EX_ALUOp_o, MEM_MemWrite_o, MEM_MemRead_o,
                          WB_RegWrite_o, WB_MemtoReg_o, WB_RegAddr_o});
    end
    nop();
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_double_hit();
    test_load_use();
    test_branch();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
